// File: rtl/regfile_write_arbiter_if.sv
// Writeback request channel: one valid/ready push
// of {addr, data} toward the register-file write arbiter.
interface regfile_write_arbiter_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
);
  logic                  valid;
  logic                  ready;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] data;

  modport master (
    output valid,
    output addr,
    output data,
    input  ready
  );

  modport slave (
    input  valid,
    input  addr,
    input  data,
    output ready
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Two-source register-file write arbiter: per-source FIFOs,
// round-robin drain into a registered write port, pending query.
module regfile_write_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int FIFO_DEPTH = 2,
  parameter int DROP_R0    = 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  regfile_write_arbiter_if.slave req0,
  regfile_write_arbiter_if.slave req1,
  input  logic [ADDR_WIDTH-1:0] query_addr,
  output logic                  query_pending,
  output logic                  sig_RegWrite,
  output logic [ADDR_WIDTH-1:0] a3,
  output logic [DATA_WIDTH-1:0] wd3,
  output logic                  busy
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_WIDTH-1:0] f_addr [2][FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] f_data [2][FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr [2];
  logic [PW-1:0]         rd_ptr [2];
  logic [CW-1:0]         count  [2];
  logic                  last_grant;

  logic [1:0]            in_valid;
  logic [ADDR_WIDTH-1:0] in_addr [2];
  logic [DATA_WIDTH-1:0] in_data [2];
  logic [1:0]            ready;
  logic [1:0]            ne;
  logic [1:0]            push;
  logic [1:0]            pop;
  logic                  sel;
  logic [ADDR_WIDTH-1:0] head_addr;
  logic [DATA_WIDTH-1:0] head_data;
  logic                  drop_head;
  logic [PW-1:0]         off;
  logic                  hit;

  assign in_valid   = {req1.valid, req0.valid};
  assign in_addr[0] = req0.addr;
  assign in_addr[1] = req1.addr;
  assign in_data[0] = req0.data;
  assign in_data[1] = req1.data;
  assign req0.ready = ready[0];
  assign req1.ready = ready[1];

  // Occupancy flags, handshake and round-robin grant
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      ne[i]    = count[i] != '0;
      ready[i] = count[i] < CW'(FIFO_DEPTH);
      push[i]  = in_valid[i] & ready[i];
    end
    pop[1]    = ne[1] & (~ne[0] | ~last_grant);
    pop[0]    = ne[0] & ~pop[1];
    sel       = pop[1];
    head_addr = f_addr[sel][rd_ptr[sel]];
    head_data = f_data[sel][rd_ptr[sel]];
    drop_head = (DROP_R0 != 0) && (head_addr == '0);
  end

  // FIFO storage, written only on an accepted push
  always_ff @(posedge clock) begin
    for (int i = 0; i < 2; i++) begin
      if (push[i]) begin
        f_addr[i][wr_ptr[i]] <= in_addr[i];
        f_data[i][wr_ptr[i]] <= in_data[i];
      end
    end
  end

  // FIFO pointers and occupancy counts
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
        unique case (1'b1)
          push[i] & ~pop[i]: count[i] <= count[i] + 1'b1;
          ~push[i] & pop[i]: count[i] <= count[i] - 1'b1;
          default:           count[i] <= count[i];
        endcase
      end
    end
  end

  // Registered write stage and grant history
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sig_RegWrite <= 1'b0;
      a3           <= '0;
      wd3          <= '0;
      last_grant   <= 1'b1;
    end else if (|pop) begin
      last_grant <= sel;
      if (drop_head) begin
        sig_RegWrite <= 1'b0;
      end else begin
        sig_RegWrite <= 1'b1;
        a3           <= head_addr;
        wd3          <= head_data;
      end
    end else begin
      sig_RegWrite <= 1'b0;
    end
  end

  // Pending-write lookup over live FIFO slots and the write stage
  always_comb begin
    hit = 1'b0;
    off = '0;
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < FIFO_DEPTH; k++) begin
        off = PW'(k) - rd_ptr[i];
        if (({1'b0, off} < count[i]) && (f_addr[i][k] == query_addr))
          hit = 1'b1;
      end
    end
    if (sig_RegWrite && (a3 == query_addr))
      hit = 1'b1;
    if ((DROP_R0 != 0) && (query_addr == '0))
      hit = 1'b0;
    query_pending = hit;
  end

  assign busy = ne[0] | ne[1] | sig_RegWrite;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: vector table, corner
// sequences and random traffic against a queue-based model.
module tb_regfile_write_arbiter;

  localparam int D  = 2;
  localparam int AW = 5;
  localparam int DW = 32;

  logic          clock;
  logic          reset_n;
  logic [AW-1:0] query_addr;
  logic          query_pending;
  logic          sig_RegWrite;
  logic [AW-1:0] a3;
  logic [DW-1:0] wd3;
  logic          busy;

  regfile_write_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) r0i ();
  regfile_write_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) r1i ();

  regfile_write_arbiter #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .FIFO_DEPTH(D),
    .DROP_R0(1)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .req0(r0i),
    .req1(r1i),
    .query_addr(query_addr),
    .query_pending(query_pending),
    .sig_RegWrite(sig_RegWrite),
    .a3(a3),
    .wd3(wd3),
    .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  ent_t          q0[$];
  ent_t          q1[$];
  bit            m_lg;
  bit            m_we;
  logic [AW-1:0] m_a3;
  logic [DW-1:0] m_wd;

  typedef struct {
    bit            rst;
    bit            v0;
    logic [AW-1:0] a0;
    bit            v1;
    logic [AW-1:0] a1;
    logic [AW-1:0] qa;
    bit            we;
    logic [AW-1:0] ea3;
    bit            src;
    bit            busy;
    bit            pend;
    bit            r0;
    bit            r1;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [DW-1:0] dat(bit src, logic [AW-1:0] a);
    return 32'hC0DE_0000 | (32'(src) << 8) | 32'(a);
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q0.delete();
    q1.delete();
    m_lg = 1'b1;
    m_we = 1'b0;
    m_a3 = '0;
    m_wd = '0;
  endtask

  // One clock edge of the reference model, using pre-edge state
  task automatic model_edge(bit v0, logic [AW-1:0] a0, logic [DW-1:0] d0,
                            bit v1, logic [AW-1:0] a1, logic [DW-1:0] d1);
    bit   rd0;
    bit   rd1;
    int   g;
    ent_t e;
    rd0 = q0.size() < D;
    rd1 = q1.size() < D;
    g = -1;
    if (q0.size() > 0 && q1.size() > 0) g = m_lg ? 0 : 1;
    else if (q0.size() > 0) g = 0;
    else if (q1.size() > 0) g = 1;
    if (g >= 0) begin
      e = (g == 1) ? q1.pop_front() : q0.pop_front();
      m_lg = (g == 1);
      if (e.a == 0) begin
        m_we = 1'b0;
      end else begin
        m_we = 1'b1;
        m_a3 = e.a;
        m_wd = e.d;
      end
    end else begin
      m_we = 1'b0;
    end
    if (v0 && rd0) q0.push_back('{a0, d0});
    if (v1 && rd1) q1.push_back('{a1, d1});
  endtask

  function automatic bit m_pend(logic [AW-1:0] qa);
    bit h;
    h = 1'b0;
    if (qa == 0) return 1'b0;
    foreach (q0[i]) if (q0[i].a == qa) h = 1'b1;
    foreach (q1[i]) if (q1[i].a == qa) h = 1'b1;
    if (m_we && m_a3 == qa) h = 1'b1;
    return h;
  endfunction

  task automatic drive(bit v0, logic [AW-1:0] a0, logic [DW-1:0] d0,
                       bit v1, logic [AW-1:0] a1, logic [DW-1:0] d1,
                       logic [AW-1:0] qa);
    r0i.valid = v0;
    r0i.addr  = v0 ? a0 : 'x;
    r0i.data  = v0 ? d0 : 'x;
    r1i.valid = v1;
    r1i.addr  = v1 ? a1 : 'x;
    r1i.data  = v1 ? d1 : 'x;
    query_addr = qa;
  endtask

  task automatic cyc(bit v0, logic [AW-1:0] a0, logic [DW-1:0] d0,
                     bit v1, logic [AW-1:0] a1, logic [DW-1:0] d1,
                     logic [AW-1:0] qa);
    @(negedge clock);
    drive(v0, a0, d0, v1, a1, d1, qa);
    @(posedge clock);
    model_edge(v0, a0, d0, v1, a1, d1);
    #1;
  endtask

  task automatic idle(logic [AW-1:0] qa);
    cyc(1'b0, '0, '0, 1'b0, '0, '0, qa);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #2;
    model_reset();
    reset_n = 1'b1;
  endtask

  task automatic chk_model(string tag);
    chk({tag, ".we"}, 32'(sig_RegWrite), 32'(m_we));
    chk({tag, ".a3"}, 32'(a3), 32'(m_a3));
    chk({tag, ".wd3"}, wd3, m_wd);
    chk({tag, ".busy"}, 32'(busy),
        32'(q0.size() > 0 || q1.size() > 0 || m_we));
    chk({tag, ".r0"}, 32'(r0i.ready), 32'(q0.size() < D));
    chk({tag, ".r1"}, 32'(r1i.ready), 32'(q1.size() < D));
    chk({tag, ".pend"}, 32'(query_pending), 32'(m_pend(query_addr)));
  endtask

  bit            h0v, h1v;
  logic [AW-1:0] h0a, h1a;
  logic [DW-1:0] h0d, h1d;
  bit            pre0, pre1;

  initial begin
    reset_n = 1'b0;
    drive(1'b0, '0, '0, 1'b0, '0, '0, 5'd3);
    model_reset();
    #12;
    reset_n = 1'b1;
    #1;
    chk("rst.we", 32'(sig_RegWrite), 32'd0);
    chk("rst.a3", 32'(a3), 32'd0);
    chk("rst.wd3", wd3, 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.r0", 32'(r0i.ready), 32'd1);
    chk("rst.r1", 32'(r1i.ready), 32'd1);
    chk("rst.pend", 32'(query_pending), 32'd0);

    // rst v0 a0 v1 a1 qa | we a3 src busy pend r0 r1
    tbl.push_back('{1, 1, 1, 1, 11, 11, 0, 0, 0, 1, 1, 1, 1});
    tbl.push_back('{0, 1, 2, 1, 12, 1, 1, 1, 0, 1, 1, 1, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 1, 1, 11, 1, 1, 0, 1, 1});
    tbl.push_back('{0, 0, 0, 0, 0, 12, 1, 2, 0, 1, 1, 1, 1});
    tbl.push_back('{0, 0, 0, 0, 0, 12, 1, 12, 1, 1, 1, 1, 1});
    tbl.push_back('{0, 0, 0, 0, 0, 12, 0, 0, 0, 0, 0, 1, 1});
    tbl.push_back('{0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1});
    tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1});
    tbl.push_back('{1, 1, 3, 1, 21, 21, 0, 0, 0, 1, 1, 1, 1});
    tbl.push_back('{0, 1, 4, 1, 22, 3, 1, 3, 0, 1, 1, 1, 0});
    tbl.push_back('{0, 0, 0, 1, 30, 30, 1, 21, 1, 1, 0, 1, 1});
    tbl.push_back('{0, 0, 0, 0, 0, 22, 1, 4, 0, 1, 1, 1, 1});
    tbl.push_back('{0, 0, 0, 0, 0, 4, 1, 22, 1, 1, 0, 1, 1});
    tbl.push_back('{0, 0, 0, 0, 0, 22, 0, 0, 0, 0, 0, 1, 1});

    foreach (tbl[i]) begin
      if (tbl[i].rst) do_reset();
      cyc(tbl[i].v0, tbl[i].a0, dat(1'b0, tbl[i].a0),
          tbl[i].v1, tbl[i].a1, dat(1'b1, tbl[i].a1), tbl[i].qa);
      chk($sformatf("v%0d.we", i), 32'(sig_RegWrite), 32'(tbl[i].we));
      if (tbl[i].we) begin
        chk($sformatf("v%0d.a3", i), 32'(a3), 32'(tbl[i].ea3));
        chk($sformatf("v%0d.wd3", i), wd3, dat(tbl[i].src, tbl[i].ea3));
      end
      chk($sformatf("v%0d.busy", i), 32'(busy), 32'(tbl[i].busy));
      chk($sformatf("v%0d.pend", i), 32'(query_pending), 32'(tbl[i].pend));
      chk($sformatf("v%0d.r0", i), 32'(r0i.ready), 32'(tbl[i].r0));
      chk($sformatf("v%0d.r1", i), 32'(r1i.ready), 32'(tbl[i].r1));
    end

    do_reset();
    cyc(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, '0, '0, 5'd5);
    chk("one.e1.we", 32'(sig_RegWrite), 32'd0);
    chk("one.e1.busy", 32'(busy), 32'd1);
    idle(5'd5);
    chk("one.e2.we", 32'(sig_RegWrite), 32'd1);
    chk("one.e2.a3", 32'(a3), 32'd5);
    chk("one.e2.wd3", wd3, 32'hDEAD_BEEF);
    idle(5'd5);
    chk("one.e3.we", 32'(sig_RegWrite), 32'd0);
    chk("one.e3.busy", 32'(busy), 32'd0);

    do_reset();
    cyc(1'b0, '0, '0, 1'b1, 5'd7, 32'h0000_0077, 5'd7);
    chk("pq.queued7", 32'(query_pending), 32'd1);
    query_addr = 5'd8;
    #1;
    chk("pq.queued8", 32'(query_pending), 32'd0);
    idle(5'd7);
    chk("pq.issue.we", 32'(sig_RegWrite), 32'd1);
    chk("pq.issue7", 32'(query_pending), 32'd1);
    query_addr = 5'd8;
    #1;
    chk("pq.issue8", 32'(query_pending), 32'd0);
    idle(5'd7);
    chk("pq.after.we", 32'(sig_RegWrite), 32'd0);
    chk("pq.after7", 32'(query_pending), 32'd0);

    do_reset();
    cyc(1'b1, 5'd1, 32'h11, 1'b1, 5'd11, 32'h1111, 5'd12);
    cyc(1'b1, 5'd2, 32'h22, 1'b1, 5'd12, 32'h1212, 5'd12);
    chk("ar.pre.we", 32'(sig_RegWrite), 32'd1);
    chk("ar.pre.pend", 32'(query_pending), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("ar.low.we", 32'(sig_RegWrite), 32'd0);
    chk("ar.low.busy", 32'(busy), 32'd0);
    chk("ar.low.pend", 32'(query_pending), 32'd0);
    model_reset();
    reset_n = 1'b1;
    cyc(1'b1, 5'd5, 32'h55, 1'b1, 5'd15, 32'h1515, 5'd5);
    idle(5'd5);
    chk("ar.first.we", 32'(sig_RegWrite), 32'd1);
    chk("ar.first.a3", 32'(a3), 32'd5);
    idle(5'd5);
    chk("ar.second.a3", 32'(a3), 32'd15);

    do_reset();
    h0v = 1'b0;
    h1v = 1'b0;
    h0a = '0;
    h1a = '0;
    h0d = '0;
    h1d = '0;
    for (int n = 0; n < 400; n++) begin
      if (!h0v && $urandom_range(0, 9) < 6) begin
        h0v = 1'b1;
        h0a = AW'($urandom_range(0, 7));
        h0d = $urandom;
      end
      if (!h1v && $urandom_range(0, 9) < 6) begin
        h1v = 1'b1;
        h1a = AW'($urandom_range(0, 7));
        h1d = $urandom;
      end
      pre0 = q0.size() < D;
      pre1 = q1.size() < D;
      cyc(h0v, h0a, h0d, h1v, h1a, h1d, AW'($urandom_range(0, 7)));
      chk_model("rnd");
      if (h0v && pre0) h0v = 1'b0;
      if (h1v && pre1) h1v = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
